// File: rtl/systolic_array.sv
// Output-stationary systolic array: A operands flow left-to-right, B operands flow top-to-bottom,
// and each PE accumulates A*B whenever it holds both and its downstream neighbours can take them.
module systolic_array #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              en_i,
  input  logic [array_height_p-1:0]                         flush_i,
  input  logic [width_p*array_height_p-1:0]                 row_i,
  input  logic [array_height_p-1:0]                         row_valid_i,
  output logic [array_height_p-1:0]                         row_ready_o,
  input  logic [width_p*array_width_p-1:0]                  col_i,
  input  logic [array_width_p-1:0]                          col_valid_i,
  output logic [array_width_p-1:0]                          col_ready_o,
  output logic [width_p*array_width_p*array_height_p-1:0]   z_o,
  output logic [array_width_p*array_height_p-1:0]           z_valid_o,
  input  logic [array_width_p*array_height_p-1:0]           z_yumi_i
);

  localparam int rows = array_height_p;
  localparam int cols = array_width_p;

  logic               a_full_w [rows][cols];
  logic               b_full_w [rows][cols];
  logic [width_p-1:0] a_w      [rows][cols];
  logic [width_p-1:0] b_w      [rows][cols];
  logic               fire_w   [rows][cols];

  // Ready looks only at registered occupancy, so a slot filled this cycle cannot be refilled.
  for (genvar r = 0; r < rows; r++) begin : g_row_ready
    assign row_ready_o[r] = en_i & ~reset_i & ~a_full_w[r][0];
  end

  for (genvar c = 0; c < cols; c++) begin : g_col_ready
    assign col_ready_o[c] = en_i & ~reset_i & ~b_full_w[0][c];
  end

  for (genvar r = 0; r < rows; r++) begin : g_row
    for (genvar c = 0; c < cols; c++) begin : g_col
      localparam int pe_idx = r + c*rows;

      logic [width_p-1:0] a_q, b_q, acc_q;
      logic               a_full_q, b_full_q, done_q;
      logic               right_free, down_free;
      logic               a_push, b_push, fire, yumi, z_valid;
      logic [width_p-1:0] a_in, b_in;

      if (c == cols-1) begin : g_right_edge
        assign right_free = 1'b1;
      end else begin : g_right_inner
        assign right_free = ~a_full_w[r][c+1];
      end

      if (r == rows-1) begin : g_bottom_edge
        assign down_free = 1'b1;
      end else begin : g_bottom_inner
        assign down_free = ~b_full_w[r+1][c];
      end

      if (c == 0) begin : g_a_from_port
        assign a_push = en_i & row_valid_i[r] & row_ready_o[r];
        assign a_in   = row_i[width_p*r +: width_p];
      end else begin : g_a_from_left
        assign a_push = fire_w[r][c-1];
        assign a_in   = a_w[r][c-1];
      end

      if (r == 0) begin : g_b_from_port
        assign b_push = en_i & col_valid_i[c] & col_ready_o[c];
        assign b_in   = col_i[width_p*c +: width_p];
      end else begin : g_b_from_above
        assign b_push = fire_w[r-1][c];
        assign b_in   = b_w[r-1][c];
      end

      // A flushed row neither fires nor hands its operands downstream.
      assign fire    = en_i & ~flush_i[r] & a_full_q & b_full_q & right_free & down_free;
      assign z_valid = done_q & ~a_full_q & ~b_full_q;
      assign yumi    = en_i & z_yumi_i[pe_idx] & z_valid;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          a_q      <= '0;
          b_q      <= '0;
          acc_q    <= '0;
          a_full_q <= 1'b0;
          b_full_q <= 1'b0;
          done_q   <= 1'b0;
        end else if (en_i) begin
          if (flush_i[r]) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            acc_q    <= '0;
            done_q   <= 1'b0;
          end else begin
            if (a_push) begin
              a_q      <= a_in;
              a_full_q <= 1'b1;
            end else if (fire) begin
              a_full_q <= 1'b0;
            end
            if (b_push) begin
              b_q      <= b_in;
              b_full_q <= 1'b1;
            end else if (fire) begin
              b_full_q <= 1'b0;
            end
            if (fire) begin
              acc_q  <= (yumi ? '0 : acc_q) + a_q * b_q;
              done_q <= 1'b1;
            end else if (yumi) begin
              acc_q  <= '0;
              done_q <= 1'b0;
            end
          end
        end
      end

      assign a_full_w[r][c] = a_full_q;
      assign b_full_w[r][c] = b_full_q;
      assign a_w[r][c]      = a_q;
      assign b_w[r][c]      = b_q;
      assign fire_w[r][c]   = fire;

      assign z_o[width_p*pe_idx +: width_p] = reset_i ? '0 : acc_q;
      assign z_valid_o[pe_idx]              = ~reset_i & z_valid;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Self-checking bench for systolic_array: directed scenarios plus randomized streams, all checked
// against a sum-of-products model built from the operands the bench itself handed to the array.
module tb_systolic_array;
  localparam int W    = 32;
  localparam int H    = 2;
  localparam int NC   = 2;
  localparam int NPE  = H*NC;
  localparam int MAXK = 16;

  localparam logic [W-1:0] EXP00 = -32'sd2103;
  localparam logic [W-1:0] EXP01 = -32'sd3707;
  localparam logic [W-1:0] EXP10 = 32'd21950;
  localparam logic [W-1:0] EXP11 = 32'd30;

  logic             clk = 1'b0;
  logic             reset, en;
  logic [H-1:0]     flush;
  logic [W*H-1:0]   row;
  logic [H-1:0]     row_valid, row_ready;
  logic [W*NC-1:0]  col;
  logic [NC-1:0]    col_valid, col_ready;
  logic [W*NPE-1:0] z;
  logic [NPE-1:0]   z_valid, z_yumi;

  int errors = 0;
  int checks = 0;

  // Model: operand sequences per row/column and how many of each the array has accepted.
  logic [W-1:0] ma [H][MAXK];
  logic [W-1:0] mb [NC][MAXK];
  int           na [H];
  int           nb [NC];

  bit               mon_on = 1'b0;
  bit               have_prev = 1'b0;
  logic [W*NPE-1:0] z_prev;
  logic             en_at_edge = 1'b0, rst_at_edge = 1'b1;

  always #5 clk = ~clk;

  systolic_array #(.width_p(W), .array_width_p(NC), .array_height_p(H)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .flush_i(flush),
    .row_i(row), .row_valid_i(row_valid), .row_ready_o(row_ready),
    .col_i(col), .col_valid_i(col_valid), .col_ready_o(col_ready),
    .z_o(z), .z_valid_o(z_valid), .z_yumi_i(z_yumi)
  );

  function automatic logic [W-1:0] zsel(int r, int c);
    return z[W*(r + c*H) +: W];
  endfunction

  function automatic logic [W-1:0] model_sum(int r, int c, int n);
    logic [W-1:0] s;
    s = '0;
    for (int k = 0; k < n; k++) s = s + ma[r][k] * mb[c][k];
    return s;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h (%0d) expected 0x%h (%0d)", name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  always @(posedge clk) begin
    en_at_edge  <= en;
    rst_at_edge <= reset;
  end

  // Every cycle: a valid result must be a partial sum of the accepted operand pairs,
  // ready must be low while disabled, and z must not move across a disabled edge.
  always @(negedge clk) begin : monitor
    int  i, lim;
    bit  found;
    if (mon_on) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < NC; c++) begin
          i = r + c*H;
          if (z_valid[i]) begin
            lim   = (na[r] < nb[c]) ? na[r] : nb[c];
            found = 1'b0;
            for (int n = 1; n <= lim; n++) if (zsel(r, c) == model_sum(r, c, n)) found = 1'b1;
            checks++;
            if (!found) begin
              errors++;
              $display("FAIL mon_partial_sum pe(%0d,%0d): got 0x%h, expected a partial sum (full 0x%h)",
                       r, c, zsel(r, c), model_sum(r, c, lim));
            end
          end
        end
      end
      if (!en) chk("mon_ready_en_low", W'({row_ready, col_ready}), '0);
      if (have_prev && !en_at_edge && !rst_at_edge && !reset) begin
        checks++;
        if (z !== z_prev) begin
          errors++;
          $display("FAIL mon_hold_en_low: got z=0x%h expected z=0x%h", z, z_prev);
        end
      end
      z_prev    <= z;
      have_prev <= 1'b1;
    end else begin
      have_prev <= 1'b0;
    end
  end

  task automatic clear_model();
    for (int r = 0; r < H; r++) na[r] = 0;
    for (int c = 0; c < NC; c++) nb[c] = 0;
  endtask

  task automatic do_reset();
    mon_on = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1; en = 1'b1; flush = '0; row_valid = '0; col_valid = '0; z_yumi = '0;
    @(negedge clk); #1;
    chk("reset_ready", W'({row_ready, col_ready}), '0);
    chk("reset_zvalid", W'(z_valid), '0);
    for (int i = 0; i < NPE; i++) chk($sformatf("reset_z[%0d]", i), z[W*i +: W], '0);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic step(logic [W-1:0] r1, logic [W-1:0] r0, logic [1:0] rv,
                      logic [W-1:0] c1, logic [W-1:0] c0, logic [1:0] cv);
    int n;
    @(negedge clk); #1;
    en = 1'b1; row = {r1, r0}; row_valid = rv; col = {c1, c0}; col_valid = cv;
    #1;
    for (int r = 0; r < H; r++) if (rv[r]) begin
      chk($sformatf("step_row_ready[%0d]", r), W'(row_ready[r]), W'(1'b1));
      if (row_ready[r]) begin ma[r][na[r]] = row[W*r +: W]; na[r]++; end
    end
    for (int c = 0; c < NC; c++) if (cv[c]) begin
      chk($sformatf("step_col_ready[%0d]", c), W'(col_ready[c]), W'(1'b1));
      if (col_ready[c]) begin mb[c][nb[c]] = col[W*c +: W]; nb[c]++; end
    end
    @(negedge clk); #1;
    row_valid = '0; col_valid = '0;
    n = 0;
    while (!((&row_ready) && (&col_ready)) && n < 8) begin @(negedge clk); #1; n++; end
    chk("step_ready_within_8", W'({row_ready, col_ready}), W'(4'hF));
    repeat (8) @(negedge clk);
  endtask

  task automatic run_stream(int k, int stall_pct, int en_pct);
    int cyc;
    bit busy;
    clear_model();
    cyc  = 0;
    busy = 1'b1;
    while (busy && cyc < 3000) begin
      @(negedge clk); #1;
      en = ($urandom_range(99) < en_pct);
      for (int r = 0; r < H; r++) begin
        row_valid[r]  = (na[r] < k) && ($urandom_range(99) >= stall_pct);
        row[W*r +: W] = (na[r] < k) ? ma[r][na[r]] : W'($urandom);
      end
      for (int c = 0; c < NC; c++) begin
        col_valid[c]  = (nb[c] < k) && ($urandom_range(99) >= stall_pct);
        col[W*c +: W] = (nb[c] < k) ? mb[c][nb[c]] : W'($urandom);
      end
      #1;
      for (int r = 0; r < H; r++) if (en && row_valid[r] && row_ready[r]) na[r]++;
      for (int c = 0; c < NC; c++) if (en && col_valid[c] && col_ready[c]) nb[c]++;
      busy = 1'b0;
      for (int r = 0; r < H; r++) if (na[r] < k) busy = 1'b1;
      for (int c = 0; c < NC; c++) if (nb[c] < k) busy = 1'b1;
      cyc++;
    end
    chk("stream_all_accepted", W'(busy), '0);
    @(negedge clk); #1;
    row_valid = '0; col_valid = '0; en = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic fill_random(int k);
    for (int j = 0; j < k; j++) begin
      for (int r = 0; r < H; r++)
        ma[r][j] = ($urandom_range(2) == 0) ? W'($urandom) : W'($urandom_range(200)) - 32'd100;
      for (int c = 0; c < NC; c++)
        mb[c][j] = ($urandom_range(2) == 0) ? W'($urandom) : W'($urandom_range(200)) - 32'd100;
    end
  endtask

  task automatic final_check(string tag, int k);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < NC; c++) begin
        chk($sformatf("%s_z(%0d,%0d)", tag, r, c), zsel(r, c), model_sum(r, c, k));
        chk($sformatf("%s_valid(%0d,%0d)", tag, r, c), W'(z_valid[r + c*H]), W'(1'b1));
      end
  endtask

  task automatic check_literals(string tag);
    chk({tag, "_z00"}, zsel(0, 0), EXP00);
    chk({tag, "_z01"}, zsel(0, 1), EXP01);
    chk({tag, "_z10"}, zsel(1, 0), EXP10);
    chk({tag, "_z11"}, zsel(1, 1), EXP11);
    chk({tag, "_zvalid"}, W'(z_valid), W'(4'hF));
  endtask

  task automatic random_yumi_flush();
    logic [W*NPE-1:0] zb;
    logic [NPE-1:0]   vb, mask;
    int               rr, i;
    zb = z; vb = z_valid; mask = NPE'($urandom);
    @(negedge clk); #1; z_yumi = mask;
    @(negedge clk); #1; z_yumi = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < NC; c++) begin
        i = r + c*H;
        chk($sformatf("rnd_yumi_z(%0d,%0d)", r, c), zsel(r, c), (mask[i] && vb[i]) ? '0 : zb[W*i +: W]);
        chk($sformatf("rnd_yumi_v(%0d,%0d)", r, c), W'(z_valid[i]), W'(vb[i] & ~mask[i]));
      end
    zb = z; vb = z_valid; rr = $urandom_range(H-1);
    @(negedge clk); #1; flush = H'(1) << rr;
    @(negedge clk); #1; flush = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < NC; c++) begin
        i = r + c*H;
        chk($sformatf("rnd_flush_z(%0d,%0d)", r, c), zsel(r, c), (r == rr) ? '0 : zb[W*i +: W]);
        chk($sformatf("rnd_flush_v(%0d,%0d)", r, c), W'(z_valid[i]), (r == rr) ? '0 : W'(vb[i]));
      end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; en = 1'b0; flush = '0; row = '0; row_valid = '0;
    col = '0; col_valid = '0; z_yumi = '0;
    do_reset();

    @(negedge clk); #1;
    chk("post_reset_ready", W'({row_ready, col_ready}), W'(4'hF));
    chk("post_reset_zvalid", W'(z_valid), '0);
    for (int i = 0; i < NPE; i++) chk($sformatf("post_reset_z[%0d]", i), z[W*i +: W], '0);

    // Skewed feed with idle gaps.
    mon_on = 1'b1;
    step(32'd0, 32'd44, 2'b01, 32'd0, 32'd22, 2'b01);
    step(32'd960, -32'sd37, 2'b11, -32'sd1, 32'd83, 2'b11);
    step(32'd10, 32'd0, 2'b10, 32'd99, 32'd0, 2'b10);
    check_literals("skew");
    chk("model_pin_00", model_sum(0, 0, 2), EXP00);
    chk("model_pin_11", model_sum(1, 1, 2), EXP11);
    mon_on = 1'b0;

    // Same operands, valid held back-to-back.
    do_reset();
    ma[0][0] = 32'd44;  ma[0][1] = -32'sd37;
    ma[1][0] = 32'd960; ma[1][1] = 32'd10;
    mb[0][0] = 32'd22;  mb[0][1] = 32'd83;
    mb[1][0] = -32'sd1; mb[1][1] = 32'd99;
    mon_on = 1'b1;
    run_stream(2, 0, 100);
    check_literals("b2b");
    mon_on = 1'b0;

    // Consume PE(0,0), then flush row 1.
    @(negedge clk); #1; z_yumi = 4'b0001;
    @(negedge clk); #1; z_yumi = '0;
    chk("yumi_z00", zsel(0, 0), '0);
    chk("yumi_zvalid", W'(z_valid), W'(4'b1110));
    chk("yumi_z01", zsel(0, 1), EXP01);
    chk("yumi_z10", zsel(1, 0), EXP10);
    chk("yumi_z11", zsel(1, 1), EXP11);
    @(negedge clk); #1; flush = 2'b10;
    @(negedge clk); #1; flush = '0;
    chk("flush_z10", zsel(1, 0), '0);
    chk("flush_z11", zsel(1, 1), '0);
    chk("flush_z01", zsel(0, 1), EXP01);
    chk("flush_zvalid", W'(z_valid), W'(4'b0100));

    // Disabled with valid inputs: nothing accepted, nothing moves.
    @(negedge clk); #1;
    en = 1'b0; row = {32'd5, 32'd7}; row_valid = 2'b11; col = {32'd3, 32'd9}; col_valid = 2'b11;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk); #1;
      chk("en_low_ready", W'({row_ready, col_ready}), '0);
      chk("en_low_z01", zsel(0, 1), EXP01);
    end
    row_valid = '0; col_valid = '0; en = 1'b1;
    repeat (6) @(negedge clk);
    chk("en_low_after_z00", zsel(0, 0), '0);
    chk("en_low_after_z01", zsel(0, 1), EXP01);
    chk("en_low_after_z10", zsel(1, 0), '0);
    chk("en_low_after_zvalid", W'(z_valid), W'(4'b0100));

    // Wrap-around product.
    do_reset();
    step(32'd0, 32'h7FFF_FFFF, 2'b01, 32'd0, 32'd2, 2'b01);
    chk("wrap_z00", zsel(0, 0), 32'hFFFF_FFFE);
    chk("wrap_valid00", W'(z_valid[0]), W'(1'b1));

    // Reset in the middle of step 2.
    do_reset();
    mon_on = 1'b1;
    step(32'd0, 32'd44, 2'b01, 32'd0, 32'd22, 2'b01);
    @(negedge clk); #1;
    row = {32'd960, -32'sd37}; row_valid = 2'b11; col = {-32'sd1, 32'd83}; col_valid = 2'b11;
    @(negedge clk); #1;
    mon_on = 1'b0; row_valid = '0; col_valid = '0; reset = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ready", W'({row_ready, col_ready}), '0);
    chk("midrst_zvalid", W'(z_valid), '0);
    chk("midrst_z00_during", zsel(0, 0), '0);
    reset = 1'b0; en = 1'b1;
    @(negedge clk); #1;
    chk("midrst_ready_after", W'({row_ready, col_ready}), W'(4'hF));
    repeat (10) @(negedge clk);
    for (int i = 0; i < NPE; i++) chk($sformatf("midrst_z[%0d]", i), z[W*i +: W], '0);
    chk("midrst_zvalid_after", W'(z_valid), '0);

    // Randomized streams with stalls and enable gaps.
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(6, 1);
      do_reset();
      fill_random(k);
      mon_on = 1'b1;
      run_stream(k, $urandom_range(60), $urandom_range(100, 60));
      final_check($sformatf("rnd%0d", it), k);
      mon_on = 1'b0;
      random_yumi_flush();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
